// File: rtl/ovf_pkg.sv
// ovf_pkg: shared types and saturation helpers for the overflow-aware
// signed datapath blocks.
//   ovf_mode_e  : add behaviour on overflow (wrap or saturate)
//   acc_state_e : output holding flag of the accumulator (EMPTY / FULL)
//   sat_max/min : largest positive / most negative two's-complement value
//                 of a given width, returned in SAT_W_MAX bits so callers
//                 truncate to their own width (valid for width <= 64)
package ovf_pkg;

   typedef enum logic {
      OVF_WRAP = 1'b0,
      OVF_SAT  = 1'b1
   } ovf_mode_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } acc_state_e;

   localparam int SAT_W_MAX = 64;

   // 0111...1 in the low 'width' bits
   function automatic logic [SAT_W_MAX-1:0] sat_max(input int width);
      return (SAT_W_MAX'(1) << (width - 1)) - SAT_W_MAX'(1);
   endfunction

   // 1000...0 in the low 'width' bits
   function automatic logic [SAT_W_MAX-1:0] sat_min(input int width);
      return SAT_W_MAX'(1) << (width - 1);
   endfunction

endpackage

// File: rtl/signed_add_ovf.sv
// signed_add_ovf: combinational WIDTH-bit two's-complement adder with
// sign-bit overflow detection and optional saturation.
//   a, b  : signed operands
//   mode  : OVF_WRAP returns the truncated sum, OVF_SAT clamps on overflow
//   sum   : result (wrapped or clamped)
//   ovf   : the true sum a+b does not fit in WIDTH bits
module signed_add_ovf
   import ovf_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   input  ovf_mode_e               mode,
   output logic signed [WIDTH-1:0] sum,
   output logic                    ovf
);

   localparam logic signed [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
   localparam logic signed [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

   logic signed [WIDTH-1:0] raw;
   logic                    sa;
   logic                    sb;
   logic                    sz;

   always_comb begin
      raw = a + b;
      sa  = a[WIDTH-1];
      sb  = b[WIDTH-1];
      sz  = raw[WIDTH-1];
      // Overflow only when both operands share a sign and the result flips it
      ovf = (!sz && sa && sb) || (sz && !sa && !sb);
      sum = raw;
      if ((mode == OVF_SAT) && ovf) begin
         // Operand sign tells which rail was crossed
         sum = sa ? SAT_MIN : SAT_MAX;
      end
   end

endmodule

// File: rtl/ovf_accumulator.sv
// ovf_accumulator: registered signed accumulator with overflow status.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake; in_data is added on accept
//   sat_mode             : 0 wrap, 1 saturate; taken at acceptance
//   clear                : synchronous clear of result, status and counter
//   out_valid/out_ready  : output handshake for acc_out / ovf_pulse
//   acc_out              : accumulator value
//   ovf_pulse            : the result in acc_out overflowed
//   ovf_sticky           : any overflow since reset/clear
//   ovf_count            : overflow events, saturating at all-ones
module ovf_accumulator
   import ovf_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             sat_mode,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] acc_out,
   output logic             ovf_pulse,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] ovf_count
);

   acc_state_e              state_q, state_d;
   logic signed [WIDTH-1:0] acc_q, acc_d;
   logic                    pulse_q, pulse_d;
   logic                    sticky_q, sticky_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic signed [WIDTH-1:0] add_sum;
   logic                    add_ovf;
   logic                    accept;
   logic                    consume;

   signed_add_ovf #(
      .WIDTH (WIDTH)
   ) u_add (
      .a    (acc_q),
      .b    ($signed(in_data)),
      .mode (ovf_mode_e'(sat_mode)),
      .sum  (add_sum),
      .ovf  (add_ovf)
   );

   // Ready depends only on our own state, out_ready and clear
   assign in_ready = !clear && ((state_q == ST_EMPTY) || out_ready);
   assign accept   = in_valid && in_ready;
   assign consume  = (state_q == ST_FULL) && out_ready;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      pulse_d  = pulse_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      if (clear) begin
         state_d  = ST_EMPTY;
         acc_d    = '0;
         pulse_d  = 1'b0;
         sticky_d = 1'b0;
         cnt_d    = '0;
      end else if (accept) begin
         // Covers both a fresh accept and consume+accept in one cycle
         state_d = ST_FULL;
         acc_d   = add_sum;
         pulse_d = add_ovf;
         if (add_ovf) begin
            sticky_d = 1'b1;
            if (!(&cnt_q)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end else if (consume) begin
         state_d = ST_EMPTY;
         pulse_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_EMPTY;
         acc_q    <= '0;
         pulse_q  <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         pulse_q  <= pulse_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_valid  = (state_q == ST_FULL);
   assign acc_out    = acc_q;
   assign ovf_pulse  = pulse_q;
   assign ovf_sticky = sticky_q;
   assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_ovf_accumulator.sv
// Testbench for ovf_accumulator (WIDTH=8, CNT_W=2). A reference model built
// on integer arithmetic predicts every registered output; accepted results
// are queued and compared when the DUT hands them downstream.
module tb_ovf_accumulator;

   localparam int WIDTH = 8;
   localparam int CNT_W = 2;
   localparam int MAXV  = (1 << (WIDTH - 1)) - 1;
   localparam int MINV  = -(1 << (WIDTH - 1));
   localparam int CMAX  = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [WIDTH-1:0] acc;
      logic             pulse;
      logic             sticky;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             sat_mode;
   logic             clear;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] acc_out;
   logic             ovf_pulse;
   logic             ovf_sticky;
   logic [CNT_W-1:0] ovf_count;

   int checks = 0;
   int errors = 0;

   exp_t sbq[$];

   logic [WIDTH-1:0] m_acc    = '0;
   logic             m_pulse  = 1'b0;
   logic             m_valid  = 1'b0;
   logic             m_sticky = 1'b0;
   int               m_cnt    = 0;

   ovf_accumulator #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .sat_mode   (sat_mode),
      .clear      (clear),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .acc_out    (acc_out),
      .ovf_pulse  (ovf_pulse),
      .ovf_sticky (ovf_sticky),
      .ovf_count  (ovf_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Applies one cycle of inputs (called at a falling edge), checks the
   // current outputs against the model, then advances model and DUT.
   task automatic cycle(input logic r, input logic c, input logic iv,
                        input logic [WIDTH-1:0] d, input logic sm, input logic ordy);
      logic exp_rdy, acc_ok, cons, ovf;
      int   s;
      exp_t e;
      rst = r; clear = c; in_valid = iv; in_data = d; sat_mode = sm; out_ready = ordy;
      #1;
      exp_rdy = !c && (!m_valid || ordy);
      check("in_ready",   32'(in_ready),   32'(exp_rdy));
      check("out_valid",  32'(out_valid),  32'(m_valid));
      check("acc_out",    32'(acc_out),    32'(m_acc));
      check("ovf_pulse",  32'(ovf_pulse),  32'(m_pulse));
      check("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
      check("ovf_count",  32'(ovf_count),  32'(m_cnt));
      cons   = m_valid && ordy && !c && !r;
      acc_ok = iv && exp_rdy && !r;
      if (cons) begin
         check("sb_nonempty", 32'(sbq.size() != 0), 32'(1));
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("sb_acc",    32'(acc_out),    32'(e.acc));
            check("sb_pulse",  32'(ovf_pulse),  32'(e.pulse));
            check("sb_sticky", 32'(ovf_sticky), 32'(e.sticky));
            check("sb_count",  32'(ovf_count),  32'(e.cnt));
         end
      end
      if (r || c) begin
         m_acc = '0; m_pulse = 1'b0; m_valid = 1'b0; m_sticky = 1'b0; m_cnt = 0;
         sbq.delete();
      end else if (acc_ok) begin
         s   = int'($signed(m_acc)) + int'($signed(d));
         ovf = (s > MAXV) || (s < MINV);
         if (sm && s > MAXV)      m_acc = WIDTH'(MAXV);
         else if (sm && s < MINV) m_acc = WIDTH'(MINV);
         else                     m_acc = WIDTH'(s);
         m_pulse = ovf;
         m_valid = 1'b1;
         if (ovf) begin
            m_sticky = 1'b1;
            if (m_cnt < CMAX) m_cnt++;
         end
         e.acc = m_acc; e.pulse = m_pulse; e.sticky = m_sticky; e.cnt = CNT_W'(m_cnt);
         sbq.push_back(e);
      end else if (cons) begin
         m_valid = 1'b0;
         m_pulse = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; sat_mode = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);

      // Reset state
      cycle(1, 0, 0, 8'h00, 0, 1);
      check("rst_acc",   32'(acc_out),   32'h00);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_cnt",   32'(ovf_count), 32'h0);

      // Wrap: 100 then +50 overflows to -106
      cycle(0, 1, 0, 8'h00, 0, 1);
      cycle(0, 0, 1, 8'h64, 0, 1);
      check("wrap_acc1",   32'(acc_out),   32'h64);
      check("wrap_pulse1", 32'(ovf_pulse), 32'h0);
      cycle(0, 0, 1, 8'h32, 0, 1);
      check("wrap_acc2",   32'(acc_out),    32'h96);
      check("wrap_pulse2", 32'(ovf_pulse),  32'h1);
      check("wrap_sticky", 32'(ovf_sticky), 32'h1);
      check("wrap_cnt",    32'(ovf_count),  32'h1);
      cycle(0, 0, 0, 8'h00, 0, 1);

      // Saturate positive
      cycle(0, 1, 0, 8'h00, 0, 1);
      cycle(0, 0, 1, 8'h64, 0, 1);
      cycle(0, 0, 1, 8'h32, 1, 1);
      check("satp_acc",   32'(acc_out),   32'h7F);
      check("satp_pulse", 32'(ovf_pulse), 32'h1);

      // Saturate negative: -100 + -50
      cycle(0, 1, 0, 8'h00, 0, 1);
      cycle(0, 0, 1, 8'h9C, 1, 1);
      cycle(0, 0, 1, 8'hCE, 1, 1);
      check("satn_acc",   32'(acc_out),   32'h80);
      check("satn_pulse", 32'(ovf_pulse), 32'h1);

      // Mixed signs never overflow: 127 + -128
      cycle(0, 1, 0, 8'h00, 0, 1);
      cycle(0, 0, 1, 8'h7F, 0, 1);
      cycle(0, 0, 1, 8'h80, 0, 1);
      check("bnd_acc",    32'(acc_out),    32'hFF);
      check("bnd_pulse",  32'(ovf_pulse),  32'h0);
      check("bnd_sticky", 32'(ovf_sticky), 32'h0);
      cycle(0, 0, 0, 8'h00, 0, 1);

      // Backpressure then consume+accept in one cycle
      cycle(0, 0, 1, 8'h01, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 1, 8'h05, 0, 0);
         check("bp_acc",   32'(acc_out),   32'h00);
         check("bp_valid", 32'(out_valid), 32'h1);
      end
      cycle(0, 0, 1, 8'h05, 0, 1);
      check("bp_new_acc", 32'(acc_out),   32'h05);
      check("bp_valid2",  32'(out_valid), 32'h1);

      // Counter saturates at 3 with CNT_W=2
      cycle(0, 1, 0, 8'h00, 0, 1);
      cycle(0, 0, 1, 8'h7F, 1, 1);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 1, 8'h7F, 1, 1);
         check("cnt_sat", 32'(ovf_count), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
         check("cnt_acc", 32'(acc_out), 32'h7F);
      end

      // Clear while in_valid=1 and out_valid=1
      cycle(0, 1, 1, 8'h11, 0, 1);
      check("clr_acc",    32'(acc_out),    32'h00);
      check("clr_valid",  32'(out_valid),  32'h0);
      check("clr_sticky", 32'(ovf_sticky), 32'h0);
      check("clr_cnt",    32'(ovf_count),  32'h0);

      // Reset in the middle of a stall
      cycle(0, 0, 1, 8'h7F, 0, 0);
      cycle(0, 0, 1, 8'h7F, 0, 0);
      cycle(1, 0, 1, 8'h33, 1, 0);
      check("rstm_acc",   32'(acc_out),   32'h00);
      check("rstm_valid", 32'(out_valid), 32'h0);
      check("rstm_pulse", 32'(ovf_pulse), 32'h0);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 29) == 0),
               1'($urandom), WIDTH'($urandom), 1'($urandom),
               ($urandom_range(0, 3) != 0));
      end

      cycle(0, 0, 0, 8'h00, 0, 1);
      cycle(0, 0, 0, 8'h00, 0, 1);
      check("sb_drained", 32'(sbq.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
